clk_period_meter: RTL

Measures the period of a slow, asynchronous clock-like input (for example a divided baud clock such as 9600 Hz derived from 50 MHz) in cycles of the fast system clock. It checks each measured period against an expected period and tolerance, and reports lock status and loss of the input. It is the checking end of the clock-divider path and is used to monitor generated clocks and recovered bit clocks.

---
 rtl/clk_period_meter_if.sv | 33 +++
 rtl/clk_period_meter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/clk_period_meter_if.sv
// Bundle between the period meter and whatever drives/consumes it.
// The master side drives enable and the measured signal.
interface clk_period_meter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 clk_in;
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 in_range;
  logic                 locked;
  logic                 timeout;

  modport master (
    output en,
    output clk_in,
    input  period,
    input  period_valid,
    input  in_range,
    input  locked,
    input  timeout
  );

  modport slave (
    input  en,
    input  clk_in,
    output period,
    output period_valid,
    output in_range,
    output locked,
    output timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous input in clk cycles and
// checks it against an expected period, reporting lock and timeout.
module clk_period_meter #(
  parameter int IN_FREQ     = 50000000,
  parameter int EXP_FREQ    = 9600,
  parameter int CNT_WIDTH   = 16,
  parameter int TOL         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input logic               clk,
  input logic               rst,
  clk_period_meter_if.slave bus
);

  localparam int EXP_PERIOD = IN_FREQ / EXP_FREQ;
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int CW1 = CNT_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;
  localparam logic [CW1-1:0] EXP_W = CW1'(EXP_PERIOD);
  localparam logic [CW1-1:0] TOL_W = CW1'(TOL);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 in_range_q, in_range_d;
  logic [LW-1:0]        lock_q, lock_d;
  logic                 locked_q, locked_d;
  logic                 pv_q, pv_d;
  logic                 to_q, to_d;

  logic [CW1-1:0]       cnt_p1;
  logic [CW1-1:0]       dev;
  logic                 hit;
  logic [CNT_WIDTH-1:0] per_sat;
  logic [LW-1:0]        lock_inc;
  logic [LW-1:0]        lock_nx;
  logic                 cnt_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Extra bit keeps cnt+1 and the deviation exact at the counter limit.
  assign cnt_p1 = {1'b0, cnt_q} + CW1'(1);
  assign dev = (cnt_p1 >= EXP_W) ? (cnt_p1 - EXP_W)
                                 : (EXP_W - cnt_p1);
  assign hit = (dev <= TOL_W);
  assign per_sat = cnt_p1[CNT_WIDTH] ? CNT_FULL
                                     : cnt_p1[CNT_WIDTH-1:0];
  assign cnt_full = (cnt_q == CNT_FULL);

  assign lock_inc = (lock_q == LOCK_MAX) ? LOCK_MAX
                                         : lock_q + LW'(1);
  assign lock_nx = hit ? lock_inc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      in_range_q <= 1'b0;
      lock_q     <= '0;
      locked_q   <= 1'b0;
      pv_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      in_range_q <= in_range_d;
      lock_q     <= lock_d;
      locked_q   <= locked_d;
      pv_q       <= pv_d;
      to_q       <= to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    in_range_d = in_range_q;
    lock_d     = lock_q;
    locked_d   = locked_q;
    pv_d       = 1'b0;
    to_d       = 1'b0;
    if (!bus.en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      lock_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) state_d = MEASURE;
        end
        MEASURE: begin
          // A rise on the last count still closes the period.
          unique case (1'b1)
            rise: begin
              period_d   = per_sat;
              pv_d       = 1'b1;
              in_range_d = hit;
              lock_d     = lock_nx;
              locked_d   = (lock_nx == LOCK_MAX);
              cnt_d      = '0;
            end
            (!rise && cnt_full): begin
              to_d     = 1'b1;
              locked_d = 1'b0;
              lock_d   = '0;
              cnt_d    = '0;
              state_d  = IDLE;
            end
            default: cnt_d = cnt_q + CNT_WIDTH'(1);
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.in_range     = in_range_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = to_q;

endmodule
